ldd_word_feeder: RTL
====================

Name: ldd_word_feeder

Overview:
- Upstream feeder for the combinational ldd decoder. It buffers 9-bit decoder input words (a..i) arriving over a valid/ready handshake in a small FIFO.
- It presents one word at a time on a registered, glitch-free bus and holds it for SETTLE cycles so the decoder's 19 outputs can settle.
- It then offers the word to the consumer, which samples the decoder outputs and acknowledges.
- It paces and isolates the decoder from bursty producers.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
SETTLE, 2, wait cycles after a new word is driven before dec_valid asserts; legal range 0..15
CW, 3, fifo_count width; equals log2(DEPTH)+1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous clear of FIFO and FSM; active high
in_valid  in  1  producer word valid
in_ready  out  1  feeder can accept a word
in_data  in  9  word; bit0=a, bit1=b ... bit8=i
dec_word  out  9  registered word driven to decoder inputs a..i (same bit map)
dec_valid  out  1  decoder outputs for dec_word are settled and may be sampled
dec_ack  in  1  consumer has sampled; pops the word
fifo_count  out  CW  occupancy, 0..DEPTH
busy  out  1  state != IDLE or fifo_count != 0

Behaviour:
- Reset (rst_n=0 at a clk edge) sets: state=IDLE, FIFO pointers=0, fifo_count=0, dec_word=0, dec_valid=0, settle counter=0. in_ready is then 1 and busy is 0.
- Clock and reset ports are clk and rst_n. There is one clock. Reset is synchronous and active-low.
- flush=1 has the same effect as reset and takes priority over push, pop and FSM activity in that cycle. A word pushed in a flush cycle is discarded. rst_n has priority over flush.
- Push condition: in_valid & in_ready.
  - in_ready = (fifo_count < DEPTH), computed from the registered count only. There is no same-cycle bypass, so a full FIFO deasserts in_ready even while a pop is happening.
  - A push writes in_data at the write pointer. The pointer wraps modulo DEPTH.
- Pop condition: state==OFFER & dec_ack. The read pointer advances modulo DEPTH.
- fifo_count updates as +1 on push only, -1 on pop only, unchanged on both.
- dec_ack is ignored when dec_valid=0.
- FSM states are IDLE, SETTLE and OFFER:
  - IDLE: if fifo_count>0, load FIFO head into dec_word. Next state is SETTLE with counter=SETTLE-1, or OFFER if SETTLE=0. Otherwise stay in IDLE; dec_word holds its last value.
  - SETTLE: dec_valid=0. If counter==0, go to OFFER; otherwise decrement.
  - OFFER: dec_valid=1. dec_word is stable for as long as dec_ack stays low.
    - On dec_ack, if fifo_count>1 (another word is present after the pop), load the next head into dec_word and go to SETTLE, or OFFER if SETTLE=0. This is back-to-back operation with no IDLE bubble.
    - Otherwise go to IDLE.
- dec_valid is a registered output: it is 1 exactly while state==OFFER.
- dec_word changes only on an IDLE/OFFER load edge, reset or flush, so the decoder sees no glitches.
- Latency: a word pushed into an empty idle feeder at edge E is loaded at edge E+1. dec_valid rises SETTLE edges later, at edge E+1+SETTLE.
  - With SETTLE=0, dec_valid is high in the cycle after the load.
- Throughput: one word per SETTLE+1 cycles when dec_ack is held high.
- A word is not popped until it has been acked. Reset or flush during SETTLE or OFFER drops the presented word and all queued words.
- Data order is strict FIFO, with no drops while rst_n=1 and flush=0.

Test Plan:
- Reset then idle, rst_n low 2 cycles -> dec_word=0, dec_valid=0, fifo_count=0, in_ready=1, busy=0.
- Single word with SETTLE=2: push 9'h0A3, dec_ack held 1 -> dec_word=0x0A3 one edge after the push. dec_valid rises 2 edges later and is high for 1 cycle. fifo_count returns 1->0.
- Fill and backpressure: push 0x001,0x002,0x004,0x008,0x010 back-to-back with dec_ack=0 -> in_ready=0 after 4 pushes and 0x010 is not accepted. fifo_count=4. Producer retries 0x010 after the first ack. Output order is 0x001,0x002,0x004,0x008,0x010.
- Back-to-back with SETTLE=0, dec_ack=1: stream 8 words with pointer wrap -> one dec_valid pulse per cycle in order, never in IDLE between words, FIFO wraps cleanly.
- Flush in OFFER: 3 words queued, flush asserted with in_valid=1 -> next cycle fifo_count=0, dec_valid=0, dec_word=0, and the in_valid word is dropped.
- Ack ignored outside OFFER: dec_ack=1 during SETTLE -> fifo_count unchanged, and the word is still offered after the settle count.

Source files
------------

// File: rtl/ldd_word_feeder.sv
// Buffers 9-bit ldd decoder input words in a small FIFO and presents them one at a time
// on a registered bus, holding each for SETTLE cycles before offering it to the consumer.
module ldd_word_feeder #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2,
  parameter int CW     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [8:0]    in_data,
  output logic [8:0]    dec_word,
  output logic          dec_valid,
  input  logic          dec_ack,
  output logic [CW-1:0] fifo_count,
  output logic          busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_OFFER  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [8:0]    word_reg;
  logic          valid_reg;
  logic          push, pop, load;
  logic [8:0]    mem [0:DEPTH-1];

  // Ready comes from the registered count only, so a full FIFO stalls even during a pop.
  assign in_ready    = (count_reg < CW'(DEPTH));
  assign push        = in_valid && in_ready;
  assign pop         = (state_reg == S_OFFER) && dec_ack;
  assign rd_ptr_next = pop ? (rd_ptr_reg + PW'(1)) : rd_ptr_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0) begin
          load     = 1'b1;
          cnt_next = SETTLE_LOAD;
          if (SETTLE == 0) state_next = S_OFFER;
          else             state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_reg == 4'd0) state_next = S_OFFER;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      S_OFFER: begin
        if (dec_ack) begin
          // Another word behind the one being acked: reload without an idle bubble.
          if (count_reg > CW'(1)) begin
            load     = 1'b1;
            cnt_next = SETTLE_LOAD;
            if (SETTLE == 0) state_next = S_OFFER;
            else             state_next = S_SETTLE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      word_reg   <= 9'd0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      valid_reg <= (state_next == S_OFFER);
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      rd_ptr_reg <= rd_ptr_next;
      if (load) word_reg <= mem[rd_ptr_next];
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; cleared pointers make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

  assign dec_word   = word_reg;
  assign dec_valid  = valid_reg;
  assign fifo_count = count_reg;
  assign busy       = (state_reg != S_IDLE) || (count_reg != '0);

endmodule
